// File: rtl/input_skew_feeder_pkg.sv
// Shared types and constants for the systolic-array feeder.
//   DATA_WIDTH     : lane width of the activation operands
//   DEFAULT_ROWS   : default number of array rows (lanes)
//   DEFAULT_LEN_W  : default width of the command vector-count field
//   feeder_state_t : command sequencer states
//   lane_t         : one signed fixed-point lane
package tpu_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned DEFAULT_ROWS  = 2;
    localparam int unsigned DEFAULT_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    typedef logic signed [DATA_WIDTH-1:0] lane_t;

endpackage

// File: rtl/input_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register carrying {valid, switch, data}
// for one lane. DEPTH=0 is a wire-through.
// Optional macro INPUT_SKEW_ZERO_BUBBLE_EN: invalid stages carry data=0;
// otherwise an invalid stage keeps its previous data.
// Ports:
//   clk, rst                    : clock, async active-low reset
//   in_valid/in_switch/in_data  : stage input
//   out_valid/out_switch/out_data : value delayed by DEPTH cycles
module skew_delay_line
#(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_switch,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_switch,
    output logic [DATA_WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_switch     = in_switch;
            assign out_data       = in_data;
        end else begin : g_shift
            logic [DEPTH-1:0]      valid_q;
            logic [DEPTH-1:0]      switch_q;
            logic [DATA_WIDTH-1:0] data_q [DEPTH];

            // valid/switch always shift; data only moves along with a valid element
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q  <= '0;
                    switch_q <= '0;
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0]  <= in_valid;
                    switch_q[0] <= in_switch;
                    if (in_valid) begin
                        data_q[0] <= in_data;
                    end
`ifdef INPUT_SKEW_ZERO_BUBBLE_EN
                    else begin
                        data_q[0] <= '0;
                    end
`endif
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        valid_q[i]  <= valid_q[i-1];
                        switch_q[i] <= switch_q[i-1];
                        if (valid_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
`ifdef INPUT_SKEW_ZERO_BUBBLE_EN
                        else begin
                            data_q[i] <= '0;
                        end
`endif
                    end
                end
            end

            assign out_valid  = valid_q[DEPTH-1];
            assign out_switch = switch_q[DEPTH-1];
            assign out_data   = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/input_skew_feeder.sv
// input_skew_feeder: west-edge feeder of the systolic PE array. Accepts one
// activation vector per cycle, delays lane r by r cycles (wavefront order),
// sequences start/stream/drain per command and pulses done at completion.
// Optional macro INPUT_SKEW_ZERO_BUBBLE_EN: out_data is forced to 0 on every
// invalid lane-cycle; otherwise it holds the lane's last valid value.
// Ports:
//   clk, rst          : clock, async active-low reset
//   cmd_start/len/switch, cmd_ready : command handshake (ready in IDLE)
//   in_data, in_valid, in_ready     : vector handshake (ready in STREAM)
//   out_data/out_valid/out_switch   : per-row PE inputs, lane r skewed by r
//   done              : one-cycle completion pulse
module input_skew_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned ROWS       = DEFAULT_ROWS,
    parameter int unsigned DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int unsigned LEN_W      = DEFAULT_LEN_W
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_start,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic                       cmd_switch,
    output logic                       cmd_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid,
    output logic [ROWS-1:0]            out_switch,
    output logic                       done
);

    localparam int unsigned DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    feeder_state_t             state;
    feeder_state_t             next_state;
    logic [LEN_W-1:0]          remaining;
    logic [DRAIN_W-1:0]        drain_cnt;
    logic                      sw_pending;

    logic                      cmd_acc_c;
    logic                      xfer_c;
    logic                      last_xfer_c;
    logic                      cmd_ready_c;
    logic                      in_ready_c;
    logic                      done_c;

    logic                      slot_valid;
    logic                      slot_switch;
    logic [ROWS*DATA_WIDTH-1:0] slot_data;

    // Handshake qualifiers use the registered ready flags (both low right after reset)
    assign cmd_acc_c   = cmd_start & cmd_ready;
    assign xfer_c      = in_valid & in_ready;
    assign last_xfer_c = xfer_c && (remaining == LEN_W'(1));

    // State register plus registered handshake/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            in_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            cmd_ready <= cmd_ready_c;
            in_ready  <= in_ready_c;
            done      <= done_c;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_acc_c) begin
                    next_state = (cmd_len != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (last_xfer_c) begin
                    next_state = (ROWS == 1) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops line up with it
    always_comb begin
        cmd_ready_c = 1'b0;
        in_ready_c  = 1'b0;
        done_c      = 1'b0;
        cmd_ready_c = (next_state == IDLE);
        in_ready_c  = (next_state == STREAM);
        done_c      = (next_state == DONE);
    end

    // Command counters: vectors still to accept and skew cycles still to drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining  <= '0;
            drain_cnt  <= '0;
            sw_pending <= 1'b0;
        end else if (cmd_acc_c) begin
            remaining  <= cmd_len;
            sw_pending <= cmd_switch;
        end else if (xfer_c) begin
            remaining  <= remaining - LEN_W'(1);
            sw_pending <= 1'b0;
            if (last_xfer_c) begin
                drain_cnt <= DRAIN_W'(ROWS - 1);
            end
        end else if ((state == DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    // Row-0 slot stage: a bubble is inserted whenever no vector is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid  <= 1'b0;
            slot_switch <= 1'b0;
            slot_data   <= '0;
        end else begin
            slot_valid  <= xfer_c;
            slot_switch <= xfer_c & sw_pending;
            if (xfer_c) begin
                slot_data <= in_data;
            end
`ifdef INPUT_SKEW_ZERO_BUBBLE_EN
            else begin
                slot_data <= '0;
            end
`endif
        end
    end

    // Lane r sees the slot stage r cycles later
    generate
        for (genvar r = 0; r < int'(ROWS); r++) begin : g_lane
            skew_delay_line #(
                .DEPTH      (r),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_delay (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (slot_valid),
                .in_switch  (slot_switch),
                .in_data    (slot_data[r*DATA_WIDTH +: DATA_WIDTH]),
                .out_valid  (out_valid[r]),
                .out_switch (out_switch[r]),
                .out_data   (out_data[r*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_input_skew_feeder.sv
// Scoreboard bench for input_skew_feeder: the driver pushes per-lane expected
// elements (value, switch tag, arrival cycle) and expected done cycles; a
// negedge monitor pops and compares whatever the DUT presents.
module tb_input_skew_feeder;

    localparam int unsigned ROWS  = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned LEN_W = 8;

    logic                 clk;
    logic                 rst;
    logic                 cmd_start;
    logic [LEN_W-1:0]     cmd_len;
    logic                 cmd_switch;
    logic                 cmd_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   out_data;
    logic [ROWS-1:0]      out_valid;
    logic [ROWS-1:0]      out_switch;
    logic                 done;

    typedef struct {
        logic [DW-1:0] data;
        bit            sw;
        int            cyc;
    } exp_t;

    exp_t           lane_q [ROWS][$];
    int             done_q [$];
    logic [DW-1:0]  last_data [ROWS];
    int             cyc = 0;
    int             checks = 0;
    int             failures = 0;

    input_skew_feeder #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DW),
        .LEN_W      (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_start  (cmd_start),
        .cmd_len    (cmd_len),
        .cmd_switch (cmd_switch),
        .cmd_ready  (cmd_ready),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_switch (out_switch),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    exp_t          m_e;
    logic [DW-1:0] m_d;
    logic [DW-1:0] m_idle;
    int            m_dc;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (out_valid !== '0 || out_switch !== '0 || out_data !== '0 ||
                done !== 1'b0 || cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold got valid=%b sw=%b data=%h done=%b cmd_ready=%b in_ready=%b expected all 0",
                         out_valid, out_switch, out_data, done, cmd_ready, in_ready);
            end
        end else begin
            for (int r = 0; r < int'(ROWS); r++) begin
                m_d = out_data[r*DW +: DW];
                checks++;
                if (out_valid[r]) begin
                    if (lane_q[r].size() == 0) begin
                        failures++;
                        $display("FAIL lane_unexpected lane=%0d cyc=%0d got data=%h expected no element", r, cyc, m_d);
                    end else begin
                        m_e = lane_q[r].pop_front();
                        last_data[r] = m_e.data;
                        if (m_d !== m_e.data || out_switch[r] !== m_e.sw || cyc != m_e.cyc) begin
                            failures++;
                            $display("FAIL lane_element lane=%0d got data=%h sw=%b cyc=%0d expected data=%h sw=%b cyc=%0d",
                                     r, m_d, out_switch[r], cyc, m_e.data, m_e.sw, m_e.cyc);
                        end
                    end
                end else begin
`ifdef INPUT_SKEW_ZERO_BUBBLE_EN
                    m_idle = '0;
`else
                    m_idle = last_data[r];
`endif
                    if (out_switch[r] !== 1'b0 || m_d !== m_idle) begin
                        failures++;
                        $display("FAIL lane_idle lane=%0d cyc=%0d got data=%h sw=%b expected data=%h sw=0",
                                 r, cyc, m_d, out_switch[r], m_idle);
                    end
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 expected 0", cyc);
                end else begin
                    m_dc = done_q.pop_front();
                    if (m_dc != cyc) begin
                        failures++;
                        $display("FAIL done_timing got cyc=%0d expected cyc=%0d", cyc, m_dc);
                    end
                end
            end
        end
    end

    task automatic wait_cmd_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL cmd_ready_timeout got cmd_ready=%b expected 1", cmd_ready);
        end
    endtask

    // Called at a negedge; asserts reset between edges and checks the immediate effect
    task automatic do_reset();
        #2;
        rst       = 1'b0;
        in_valid  = 1'b0;
        cmd_start = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0 || out_switch !== '0 || out_data !== '0 ||
            done !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got valid=%b sw=%b data=%h done=%b cmd_ready=%b expected all 0",
                     out_valid, out_switch, out_data, done, cmd_ready);
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            lane_q[r].delete();
            last_data[r] = '0;
        end
        done_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic wait_drained();
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 100) begin
            busy = (done_q.size() != 0);
            for (int r = 0; r < int'(ROWS); r++) begin
                if (lane_q[r].size() != 0) busy = 1'b1;
            end
            if (busy) begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL drain_timeout got pending done=%0d lane0=%0d expected 0 pending",
                     done_q.size(), lane_q[0].size());
        end
    endtask

    // One command; abort_after>0 resets the DUT after that many transfers
    task automatic run_cmd(input int len, input bit sw, input int bubble_pct,
                           input bit poke, input bit extreme, input int abort_after);
        int                 sent;
        int                 guard;
        int                 stop;
        logic [ROWS*DW-1:0] v;
        stop = (abort_after > 0) ? abort_after : len;
        wait_cmd_ready();
        cmd_start  = 1'b1;
        cmd_len    = LEN_W'(len);
        cmd_switch = sw;
        if (len == 0) done_q.push_back(cyc + 1);
        @(negedge clk);
        cmd_start = 1'b0;
        sent  = 0;
        guard = 0;
        while (sent < stop && guard < 200) begin
            guard++;
            if (poke) begin
                cmd_start  = 1'b1;
                cmd_len    = LEN_W'(7);
                cmd_switch = 1'b1;
            end
            for (int r = 0; r < int'(ROWS); r++) begin
                if (extreme) v[r*DW +: DW] = (((sent + r) % 2) == 0) ? 16'h7FFF : 16'h8000;
                else         v[r*DW +: DW] = DW'($urandom);
            end
            in_data  = v;
            in_valid = (int'($urandom_range(99)) >= bubble_pct);
            if (in_valid && in_ready) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    lane_q[r].push_back(exp_t'{v[r*DW +: DW], (sw && sent == 0), cyc + 1 + r});
                end
                sent++;
                if (sent == len) done_q.push_back(cyc + int'(ROWS) + 1);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        cmd_start = 1'b0;
        checks++;
        if (sent < stop) begin
            failures++;
            $display("FAIL stream_timeout got sent=%0d expected %0d", sent, stop);
        end
        if (abort_after > 0) begin
            @(negedge clk);
            do_reset();
        end else begin
            wait_drained();
        end
    endtask

    initial begin
        rst        = 1'b0;
        cmd_start  = 1'b0;
        cmd_len    = '0;
        cmd_switch = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) last_data[r] = '0;
        #3;
        checks++;
        if (out_valid !== '0 || out_data !== '0 || done !== 1'b0 || cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got valid=%b data=%h done=%b cmd_ready=%b in_ready=%b expected all 0",
                     out_valid, out_data, done, cmd_ready, in_ready);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;

        run_cmd(3, 1'b1, 0,  1'b0, 1'b0, 0);   // back-to-back vectors with switch tag
        run_cmd(3, 1'b1, 40, 1'b0, 1'b0, 0);   // bubbles in the stream
        run_cmd(0, 1'b1, 0,  1'b0, 1'b0, 0);   // empty command
        run_cmd(5, 1'b0, 20, 1'b1, 1'b0, 0);   // cmd_start during STREAM ignored
        run_cmd(6, 1'b1, 0,  1'b0, 1'b0, 2);   // reset mid-stream
        run_cmd(4, 1'b1, 0,  1'b0, 1'b0, 0);   // normal command after reset
        run_cmd(6, 1'b0, 50, 1'b0, 1'b1, 0);   // extreme values with bubbles
        for (int i = 0; i < 30; i++) begin
            run_cmd(int'($urandom_range(9)), 1'($urandom_range(1)), int'($urandom_range(60)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 0);
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
